// File: rtl/prbs_checker_if.sv
// Serial PRBS link between a bit source and the checker: DIN qualified by DIN_VALID, plus CLEAR.
// Status and counters flow back to the source side.
interface prbs_checker_if;
  logic        DIN;
  logic        DIN_VALID;
  logic        CLEAR;
  logic        LOCKED;
  logic [57:0] RECV_CNT;
  logic [63:0] ERR_CNT;

  modport master (
    output DIN, DIN_VALID, CLEAR,
    input  LOCKED, RECV_CNT, ERR_CNT
  );

  modport slave (
    input  DIN, DIN_VALID, CLEAR,
    output LOCKED, RECV_CNT, ERR_CNT
  );
endinterface

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) checker: seed, verify, lock; saturating counters updated one cycle after each valid bit.
// No backpressure: every valid bit is consumed, DIN_VALID gaps of any length simply freeze the state.
module prbs_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 8,
  parameter int WIN_LEN    = 128
) (
  input  logic           CLK,
  input  logic           RST,
  prbs_checker_if.slave  bus
);

  localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;

  state_e               state_q,    state_d;
  logic [6:0]           r_q,        r_d;
  logic [2:0]           seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]   match_q,    match_d;
  logic [WIN_W-1:0]     win_bit_q,  win_bit_d;
  logic [WERR_W-1:0]    win_err_q,  win_err_d;
  logic [57:0]          recv_q,     recv_d;
  logic [63:0]          err_q,      err_d;
  logic                 locked_q,   locked_d;

  logic                 exp_bit;
  logic                 mism;
  logic [WERR_W-1:0]    win_err_nx;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    seed_cnt_d = seed_cnt_q;
    match_d    = match_q;
    win_bit_d  = win_bit_q;
    win_err_d  = win_err_q;
    recv_d     = recv_q;
    err_d      = err_q;
    exp_bit    = r_q[6] ^ r_q[5];
    mism       = bus.DIN ^ exp_bit;
    win_err_nx = win_err_q + WERR_W'(mism);

    if (bus.DIN_VALID) begin
      case (state_q)
        ST_SEED: begin
          r_d = {r_q[5:0], bus.DIN};
          if (seed_cnt_q == 3'd6) begin
            state_d    = ST_VERIFY;
            seed_cnt_d = 3'd0;
            match_d    = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end

        ST_VERIFY: begin
          if (mism) begin
            // Reference is reloaded from scratch, so the bad bit is simply dropped.
            state_d    = ST_SEED;
            seed_cnt_d = 3'd0;
            match_d    = '0;
          end else begin
            r_d = {r_q[5:0], exp_bit};
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d   = ST_LOCK;
              match_d   = '0;
              win_bit_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end
        end

        ST_LOCK: begin
          r_d = {r_q[5:0], exp_bit};
          if (!(&recv_q)) begin
            recv_d = recv_q + 58'd1;
          end
          // Bounding by the new receive count keeps ERR_CNT <= RECV_CNT once RECV_CNT saturates.
          if (mism && (err_q < {6'd0, recv_d})) begin
            err_d = err_q + 64'd1;
          end
          if (win_err_nx == WERR_W'(UNLOCK_ERR)) begin
            state_d    = ST_SEED;
            seed_cnt_d = 3'd0;
            win_bit_d  = '0;
            win_err_d  = '0;
          end else if (win_bit_q == WIN_W'(WIN_LEN - 1)) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WIN_W'(1);
            win_err_d = win_err_nx;
          end
        end

        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = 3'd0;
        end
      endcase
    end

    if (bus.CLEAR) begin
      recv_d = '0;
      err_d  = '0;
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_SEED;
      r_q        <= '0;
      seed_cnt_q <= '0;
      match_q    <= '0;
      win_bit_q  <= '0;
      win_err_q  <= '0;
      recv_q     <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      seed_cnt_q <= seed_cnt_d;
      match_q    <= match_d;
      win_bit_q  <= win_bit_d;
      win_err_q  <= win_err_d;
      recv_q     <= recv_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.LOCKED   = locked_q;
  assign bus.RECV_CNT = recv_q;
  assign bus.ERR_CNT  = err_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive matching bits in VERIFY required to enter LOCK.
REQ-002 SHALL have parameter UNLOCK_ERR, default 8: errors within one window that force loss of lock.
REQ-003 SHALL have parameter WIN_LEN, default 128: window length in valid bits.
REQ-004 SHALL have port CLK, input, 1: sole clock, all state on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port DIN, input, 1: received serial bit.
REQ-007 SHALL have port DIN_VALID, input, 1: DIN qualifier; gaps of any length allowed.
REQ-008 SHALL have port CLEAR, input, 1: zero both counters, one-cycle pulse.
REQ-009 SHALL have port LOCKED, output, 1: high while in state LOCK.
REQ-010 SHALL have port RECV_CNT, output, 58: bits checked while locked.
REQ-011 SHALL have port ERR_CNT, output, 64: mismatched bits while locked.

Function
REQ-012 SHALL check PRBS7, x^7+x^6+1, 7-bit register R, expected bit E = R[6] xor R[5].
REQ-013 SHALL leave all state unchanged on any cycle with DIN_VALID low, except CLEAR.
REQ-014 SHALL implement states SEED, VERIFY and LOCK.
REQ-015 SEED SHALL shift DIN into R on each valid bit, with no comparison.
REQ-016 SEED SHALL go to VERIFY on the 7th valid bit, with the match counter at 0.
REQ-017 VERIFY and LOCK SHALL compare DIN with E on each valid bit, then shift E (not DIN) into R, so R free-runs and a received error never corrupts the reference.
REQ-018 A VERIFY mismatch SHALL go to SEED, with the seed bit count reset to 0 and that bit discarded.
REQ-019 VERIFY SHALL go to LOCK on the LOCK_CNT-th consecutive match.
REQ-020 In LOCK, each valid bit SHALL increment RECV_CNT by 1, and each mismatch SHALL also increment ERR_CNT by 1.
REQ-021 Counter updates SHALL be visible the cycle after the valid bit, i.e. one-cycle latency.
REQ-022 Bits in SEED/VERIFY SHALL never be counted.
REQ-023 RECV_CNT and ERR_CNT SHALL saturate at all-ones and never wrap, each independently.
REQ-024 In LOCK, a window bit counter SHALL count valid bits 0..WIN_LEN-1 and a window error counter SHALL count mismatches.
REQ-025 Both window counters SHALL clear when the window bit counter wraps to 0, and on LOCK entry.
REQ-026 When the window error count reaches UNLOCK_ERR, LOCK SHALL go to SEED; the causing bit SHALL still be counted in RECV_CNT/ERR_CNT.
REQ-027 On loss of lock, RECV_CNT/ERR_CNT SHALL hold, not clear.
REQ-028 LOCKED SHALL be registered: high the cycle after the LOCK-entering bit, low the cycle after the lock-losing bit.
REQ-029 CLEAR SHALL set RECV_CNT = ERR_CNT = 0 next cycle.
REQ-030 CLEAR SHALL have priority over a coincident increment; that bit is not counted.
REQ-031 CLEAR SHALL not affect state, R or window counters.
REQ-032 ERR_CNT <= RECV_CNT SHALL hold at all times, including saturation.
REQ-033 Outputs SHALL be stable between valid bits, so the downstream display can sample them at any cycle.

Reset
REQ-034 RST high at a clock edge SHALL set state SEED, R = 0, all internal counters 0, LOCKED = 0, RECV_CNT = 0, ERR_CNT = 0.
REQ-035 Reset SHALL have priority over CLEAR and DIN_VALID.
REQ-036 Reset mid-lock SHALL abandon lock immediately, without waiting for a window boundary.

Verification
REQ-037 Bench SHALL cover: reset then idle 10 cycles -> LOCKED = 0, RECV_CNT = 0, ERR_CNT = 0.
REQ-038 Bench SHALL cover: clean PRBS7 stream, valid every cycle -> LOCKED rises the cycle after valid bit 23 (7 + 16); after 100 further bits RECV_CNT = 100, ERR_CNT = 0.
REQ-039 Bench SHALL cover: locked, one bit inverted among 200 -> RECV_CNT = 200, ERR_CNT = 1, LOCKED stays 1, and no further errors follow, proving no error propagation.
REQ-040 Bench SHALL cover: locked, 8 inverted bits within one 128-bit window -> LOCKED falls the cycle after the 8th error, ERR_CNT = 8, and counters hold thereafter.
REQ-041 Bench SHALL cover: 7 errors in window N plus 7 errors in window N+1 -> LOCKED stays 1, ERR_CNT = 14.
REQ-042 Bench SHALL cover: CLEAR coincident with an inverted valid bit while locked -> both counters 0 next cycle, LOCKED stays 1, and the next clean bit gives RECV_CNT = 1, ERR_CNT = 0.
